ok_pattern_engine: RTL and testbench

Parametrised pattern generator and checker for host-interface throughput and integrity testing. The generator feeds an okPipeOut endpoint with LFSR, counter or walking-ones words. The checker compares words arriving from an okPipeIn endpoint against an identically seeded reference generator and keeps error statistics for okWireOut readback. It sits between the okHost endpoint fabric and the status wires, all on ti_clk.

---
 rtl/ok_pattern_engine.sv | 121 ++++++++++++
 tb/tb_ok_pattern_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ok_pattern_engine.sv
// rtl/ok_pattern_engine.sv - pattern generator and checker for host-pipe throughput/integrity tests
module ok_pattern_engine #(
  parameter int DATA_W = 16,
  parameter int STATE_W = 32,
  parameter logic [STATE_W-1:0] TAPS = 32'h8020_0002,
  parameter int ERR_W = 16,
  parameter int IDX_W = 32
) (
  input  logic               ti_clk,
  input  logic               reset,
  input  logic [1:0]         pattern_sel,
  input  logic [1:0]         run_mode,
  input  logic [STATE_W-1:0] seed,
  input  logic               seed_load,
  input  logic               clear_stats,
  input  logic               pipe_read,
  output logic [DATA_W-1:0]  pipe_dout,
  input  logic               pipe_write,
  input  logic [DATA_W-1:0]  pipe_din,
  output logic [DATA_W-1:0]  gen_word,
  output logic [ERR_W-1:0]   err_count,
  output logic               err_flag,
  output logic [IDX_W-1:0]   first_err_idx,
  output logic [IDX_W-1:0]   chk_count
);

  localparam logic [1:0] PAT_OFF  = 2'd0;
  localparam logic [1:0] PAT_LFSR = 2'd1;
  localparam logic [1:0] PAT_CNT  = 2'd2;
  localparam logic [1:0] PAT_WALK = 2'd3;

  localparam logic [1:0] MODE_CONT  = 2'd1;
  localparam logic [1:0] MODE_PIPED = 2'd2;

  localparam logic [STATE_W-1:0] STATE_ONE = {{(STATE_W-1){1'b0}}, 1'b1};

  logic [STATE_W-1:0] gen_state;
  logic [STATE_W-1:0] chk_state;
  logic [STATE_W-1:0] gen_nxt;
  logic [STATE_W-1:0] chk_nxt;
  logic [STATE_W-1:0] load_val;
  logic               gen_adv;
  logic               chk_adv;
  logic               mismatch;

  function automatic logic [STATE_W-1:0] step_fn(input logic [STATE_W-1:0] s,
                                                 input logic [1:0] sel);
    logic [STATE_W-1:0] r;
    case (sel)
      PAT_LFSR: r = {s[STATE_W-2:0], ^(s & TAPS)};
      PAT_CNT:  r = s + STATE_ONE;
      PAT_WALK: r = {s[STATE_W-2:0], s[STATE_W-1]};
      default:  r = s;
    endcase
    return r;
  endfunction

  always_comb begin
    load_val = seed;
    // an all-zero state never leaves zero for the shift-based patterns
    if (seed == '0 && (pattern_sel == PAT_LFSR || pattern_sel == PAT_WALK))
      load_val = STATE_ONE;

    gen_adv  = (run_mode == MODE_CONT) || (run_mode == MODE_PIPED && pipe_read);
    chk_adv  = pipe_write && !seed_load;
    mismatch = chk_adv && (pipe_din != chk_state[DATA_W-1:0]);

    gen_nxt = gen_state;
    if (seed_load)
      gen_nxt = load_val;
    else if (gen_adv)
      gen_nxt = step_fn(gen_state, pattern_sel);

    chk_nxt = chk_state;
    if (seed_load)
      chk_nxt = load_val;
    else if (chk_adv)
      chk_nxt = step_fn(chk_state, pattern_sel);
  end

  // pipe_dout is loaded from the next state so it always equals gen_state
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      gen_state     <= STATE_ONE;
      chk_state     <= STATE_ONE;
      pipe_dout     <= STATE_ONE[DATA_W-1:0];
      gen_word      <= STATE_ONE[DATA_W-1:0];
      err_count     <= '0;
      err_flag      <= 1'b0;
      first_err_idx <= '0;
      chk_count     <= '0;
    end else begin
      gen_state <= gen_nxt;
      chk_state <= chk_nxt;
      pipe_dout <= gen_nxt[DATA_W-1:0];
      gen_word  <= gen_nxt[DATA_W-1:0];

      if (clear_stats) begin
        err_count     <= '0;
        err_flag      <= 1'b0;
        first_err_idx <= '0;
        chk_count     <= '0;
      end else begin
        if (seed_load)
          chk_count <= '0;
        else if (pipe_write)
          chk_count <= chk_count + 1'b1;

        if (mismatch) begin
          if (err_count != '1)
            err_count <= err_count + 1'b1;
          if (!err_flag) begin
            first_err_idx <= chk_count;
            err_flag      <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ok_pattern_engine.sv
// tb/tb_ok_pattern_engine.sv - randomized self-checking bench for ok_pattern_engine
module tb_ok_pattern_engine;

  localparam logic [31:0] TAPS_M = 32'h8020_0002;

  logic        ti_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pattern_sel = 2'd0;
  logic [1:0]  run_mode = 2'd0;
  logic [31:0] seed = 32'd0;
  logic        seed_load = 1'b0;
  logic        clear_stats = 1'b0;
  logic        pipe_read = 1'b0;
  logic        pipe_write = 1'b0;
  logic [15:0] pipe_din = 16'd0;

  logic [15:0] pipe_dout, gen_word;
  logic [15:0] err_count;
  logic        err_flag;
  logic [31:0] first_err_idx, chk_count;

  logic [15:0] s_pipe_dout, s_gen_word;
  logic [3:0]  s_err_count;
  logic        s_err_flag;
  logic [31:0] s_first_err_idx, s_chk_count;

  int total = 0;
  int bad = 0;

  always #5 ti_clk = ~ti_clk;

  ok_pattern_engine u_dut (
    .ti_clk(ti_clk), .reset(reset), .pattern_sel(pattern_sel), .run_mode(run_mode),
    .seed(seed), .seed_load(seed_load), .clear_stats(clear_stats),
    .pipe_read(pipe_read), .pipe_dout(pipe_dout), .pipe_write(pipe_write),
    .pipe_din(pipe_din), .gen_word(gen_word), .err_count(err_count),
    .err_flag(err_flag), .first_err_idx(first_err_idx), .chk_count(chk_count)
  );

  ok_pattern_engine #(.ERR_W(4)) u_small (
    .ti_clk(ti_clk), .reset(reset), .pattern_sel(pattern_sel), .run_mode(run_mode),
    .seed(seed), .seed_load(seed_load), .clear_stats(clear_stats),
    .pipe_read(pipe_read), .pipe_dout(s_pipe_dout), .pipe_write(pipe_write),
    .pipe_din(pipe_din), .gen_word(s_gen_word), .err_count(s_err_count),
    .err_flag(s_err_flag), .first_err_idx(s_first_err_idx), .chk_count(s_chk_count)
  );

  // reference model state
  logic [31:0] m_gen, m_chk, m_first, m_cnt;
  int          m_err, m_err4;
  bit          m_flag;

  function automatic logic [31:0] m_step(input logic [31:0] s, input logic [1:0] sel);
    case (sel)
      2'd1: return (s << 1) | 32'($countones(s & TAPS_M) % 2);
      2'd2: return s + 32'd1;
      2'd3: return (s << 1) | (s >> 31);
      default: return s;
    endcase
  endfunction

  task automatic model_update();
    logic [31:0] v;
    bool_blk: begin
      if (reset) begin
        m_gen = 1; m_chk = 1; m_err = 0; m_err4 = 0; m_flag = 0; m_first = 0; m_cnt = 0;
        disable bool_blk;
      end
      if (seed_load) begin
        v = seed;
        if (v == 0 && (pattern_sel == 2'd1 || pattern_sel == 2'd3)) v = 1;
        m_gen = v;
        m_chk = v;
        m_cnt = 0;
      end else begin
        if (run_mode == 2'd1 || (run_mode == 2'd2 && pipe_read))
          m_gen = m_step(m_gen, pattern_sel);
        if (pipe_write) begin
          if (pipe_din != m_chk[15:0] && !clear_stats) begin
            if (m_err < 65535) m_err++;
            if (m_err4 < 15) m_err4++;
            if (!m_flag) begin
              m_first = m_cnt;
              m_flag = 1;
            end
          end
          m_chk = m_step(m_chk, pattern_sel);
          m_cnt = m_cnt + 1;
        end
      end
      if (clear_stats) begin
        m_err = 0; m_err4 = 0; m_flag = 0; m_first = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    expect_eq("gen_word", 64'(gen_word), 64'(m_gen[15:0]));
    expect_eq("pipe_dout", 64'(pipe_dout), 64'(m_gen[15:0]));
    expect_eq("err_count", 64'(err_count), 64'(m_err));
    expect_eq("err_flag", 64'(err_flag), 64'(m_flag));
    expect_eq("first_err_idx", 64'(first_err_idx), 64'(m_first));
    expect_eq("chk_count", 64'(chk_count), 64'(m_cnt));
    expect_eq("s_err_count", 64'(s_err_count), 64'(m_err4));
    expect_eq("s_err_flag", 64'(s_err_flag), 64'(m_flag));
    expect_eq("s_first_err_idx", 64'(s_first_err_idx), 64'(m_first));
    expect_eq("s_chk_count", 64'(s_chk_count), 64'(m_cnt));
    expect_eq("s_gen_word", 64'(s_gen_word), 64'(m_gen[15:0]));
    expect_eq("s_pipe_dout", 64'(s_pipe_dout), 64'(m_gen[15:0]));
  endtask

  task automatic tick();
    @(posedge ti_clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic do_seed(input logic [1:0] sel, input logic [31:0] s);
    pattern_sel = sel;
    seed = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] d);
    pipe_write = 1'b1;
    pipe_din = d;
    tick();
    pipe_write = 1'b0;
  endtask

  initial begin
    logic [15:0] wr_list [5];
    wr_list = '{16'h10, 16'h11, 16'h99, 16'h13, 16'h77};

    // reset state
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    expect_eq("rst_gen_word", 64'(gen_word), 64'h1);

    // counter, piped reads with idle gaps
    run_mode = 2'd2;
    do_seed(2'd2, 32'h5);
    for (int i = 0; i < 3; i++) begin
      expect_eq("piped_word", 64'(pipe_dout), 64'(16'h5 + 16'(i)));
      pipe_read = 1'b1;
      tick();
      pipe_read = 1'b0;
      tick();
    end
    expect_eq("piped_after", 64'(pipe_dout), 64'h8);

    // LFSR zero seed guard then continuous stepping
    run_mode = 2'd0;
    do_seed(2'd1, 32'h0);
    expect_eq("lfsr_guard", 64'(gen_word), 64'h1);
    run_mode = 2'd1;
    tick();
    expect_eq("lfsr_step1", 64'(gen_word), 64'h2);
    tick();
    expect_eq("lfsr_step2", 64'(gen_word), 64'h5);
    for (int i = 0; i < 32; i++) tick();
    run_mode = 2'd0;

    // checker pass/fail
    clear_stats = 1'b1;
    do_seed(2'd2, 32'h10);
    clear_stats = 1'b0;
    foreach (wr_list[i]) do_write(wr_list[i]);
    expect_eq("chk_err", 64'(err_count), 64'd2);
    expect_eq("chk_flag", 64'(err_flag), 64'd1);
    expect_eq("chk_first", 64'(first_err_idx), 64'd2);
    expect_eq("chk_cnt", 64'(chk_count), 64'd5);

    // saturation on the narrow counter, then clear
    for (int i = 0; i < 20; i++) do_write(~m_chk[15:0]);
    expect_eq("sat_small", 64'(s_err_count), 64'd15);
    expect_eq("sat_big", 64'(err_count), 64'd22);
    clear_stats = 1'b1;
    do_write(~m_chk[15:0]);
    clear_stats = 1'b0;
    expect_eq("clr_err", 64'(err_count), 64'd0);
    expect_eq("clr_flag", 64'(err_flag), 64'd0);
    expect_eq("clr_cnt", 64'(chk_count), 64'd0);

    // seed_load collides with read and write
    run_mode = 2'd2;
    pipe_read = 1'b1;
    pipe_write = 1'b1;
    pipe_din = 16'hDEAD;
    do_seed(2'd2, 32'h40);
    pipe_read = 1'b0;
    pipe_write = 1'b0;
    expect_eq("col_word", 64'(gen_word), 64'h40);
    expect_eq("col_cnt", 64'(chk_count), 64'd0);
    expect_eq("col_err", 64'(err_count), 64'd0);

    // walking one wraps from the top bit
    run_mode = 2'd0;
    do_seed(2'd3, 32'h8000_0000);
    expect_eq("walk_top", 64'(gen_word), 64'h0);
    run_mode = 2'd1;
    tick();
    expect_eq("walk_wrap", 64'(gen_word), 64'h1);

    // reset mid-stream with an in-flight mismatching write
    do_seed(2'd1, 32'h0000_ACE1);
    for (int i = 0; i < 4; i++) tick();
    pipe_write = 1'b1;
    pipe_din = ~m_chk[15:0];
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pipe_write = 1'b0;
    expect_eq("midrst_word", 64'(gen_word), 64'h1);
    expect_eq("midrst_err", 64'(err_count), 64'd0);
    expect_eq("midrst_cnt", 64'(chk_count), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 499) == 0);
      seed_load   = ($urandom_range(0, 59) == 0);
      clear_stats = ($urandom_range(0, 199) == 0);
      seed        = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 39) == 0) pattern_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) run_mode = 2'($urandom_range(0, 3));
      pipe_read  = $urandom_range(0, 1) == 1;
      pipe_write = $urandom_range(0, 1) == 1;
      pipe_din   = ($urandom_range(0, 3) != 0) ? m_chk[15:0] : 16'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
